// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO read-drain slice.
// Default data width, drain FSM states and the FIFO word type.
package fifo_pkg;

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

  typedef logic [DATA_W-1:0] fifo_word_t;

endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: DEPTH-entry circular buffer absorbing FIFO read latency.
// Ports: clk, rst, push/wdata (tail write), pop (head advance), rdata (head), occ.
module drain_skid_buf #(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 2,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [OW-1:0]     occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdata = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      unique case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && occ == OW'(DEPTH)));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst) !(pop && occ == '0));

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side master draining a FIFO into a valid/ready stream.
// Ports: FIFO side (o_empty, o_alm_empty, o_rddata, i_rden), stream (m_*), enable, idle, beat_cnt.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              o_empty,
  input  logic              o_alm_empty,
  input  logic [DATA_W-1:0] o_rddata,
  output logic              i_rden,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              idle,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int BUF_D = RD_LAT + 1;
  localparam int OW    = $clog2(BUF_D + 1);
  localparam int SW    = OW + 2;

  drain_state_e      state;
  drain_state_e      state_nxt;
  logic [RD_LAT-1:0] pipe;
  logic [OW-1:0]     occ;
  logic [SW-1:0]     used;
  logic [SW-1:0]     room;
  logic              tap;
  logic              rden_q;
  logic              fire;
  logic              has_credit;

  assign tap     = pipe[RD_LAT-1];
  assign rden_q  = pipe[0];
  assign m_valid = occ != '0;
  assign fire    = m_valid && m_ready;
  assign idle    = state == OFF;

  // A word leaving this cycle frees its slot before a new read can
  // land, so RD_LAT+1 entries still sustain one word per cycle.
  assign used       = SW'(occ) + SW'($countones(pipe));
  assign room       = SW'(BUF_D) + SW'(fire);
  assign has_credit = used < room;

  // With one word left the flags may be a cycle stale: space reads out.
  assign i_rden = (state == RUN) && !o_empty && has_credit
                  && !(o_alm_empty && rden_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:     if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP: begin
        if (enable)          state_nxt = RUN;
        else if (used == '0) state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      pipe     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      pipe  <= RD_LAT'({pipe, i_rden});
      if (fire) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  drain_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_D)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (tap),
    .pop   (fire),
    .wdata (o_rddata),
    .rdata (m_data),
    .occ   (occ)
  );

  a_no_empty_read: assert property (
    @(posedge clk) disable iff (rst) !(i_rden && o_empty));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed + random bench with a queue-based FIFO and scoreboard.
// FIFO flags lag occupancy by one cycle to exercise the read-spacing rule.
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  localparam int RD_LAT = 1;
  localparam int BUF_D  = RD_LAT + 1;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             o_empty = 1'b1;
  logic             o_alm_empty = 1'b1;
  logic             m_ready = 1'b0;
  fifo_word_t       o_rddata;
  logic             i_rden;
  logic             m_valid;
  logic             idle;
  fifo_word_t       m_data;
  logic [CNT_W-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  fifo_word_t fifo_q[$];
  fifo_word_t exp_q[$];
  fifo_word_t rd_pipe [RD_LAT];

  int cyc = 0;
  int rd_count = 0;
  int fire_count = 0;
  int valid_count = 0;
  int first_rd = -1;
  int first_fire = -1;
  int last_fire = -1;
  int beats_model = 0;
  logic prev_stall = 1'b0;
  fifo_word_t prev_data = '0;

  always #5 clk = ~clk;

  fifo_rd_drain #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata),
    .i_rden      (i_rden),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .idle        (idle),
    .beat_cnt    (beat_cnt)
  );

  task automatic chk(input string tag, input fifo_word_t got,
                     input fifo_word_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO: flags describe the occupancy of the previous cycle.
  always @(posedge clk) begin
    int sz;
    sz = fifo_q.size();
    o_empty     <= (sz == 0);
    o_alm_empty <= (sz <= 1);
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (i_rden && sz > 0) begin
      rd_pipe[0] <= fifo_q[0];
      exp_q.push_back(fifo_q.pop_front());
    end else begin
      rd_pipe[0] <= {4{$urandom}};
    end
  end

  assign o_rddata = rd_pipe[RD_LAT-1];

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("beat_cnt", fifo_word_t'(beat_cnt), fifo_word_t'(beats_model));
      if (i_rden) begin
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
        chk("no_underflow", fifo_word_t'(fifo_q.size() > 0), fifo_word_t'(1));
      end
      if (prev_stall) begin
        chk("hold_valid", fifo_word_t'(m_valid), fifo_word_t'(1));
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid) valid_count++;
      if (m_valid && m_ready) begin
        fire_count++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        chk("word_expected", fifo_word_t'(exp_q.size() != 0), fifo_word_t'(1));
        if (exp_q.size() != 0) chk("data_order", m_data, exp_q.pop_front());
        beats_model = (beats_model + 1) % (1 << CNT_W);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(fifo_word_t'(base + i));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && !idle; i++) step(1);
    chk(tag, fifo_word_t'(idle), fifo_word_t'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int f0;
    int v0;
    int n;

    step(3);
    chk("rst_rden", fifo_word_t'(i_rden), fifo_word_t'(0));
    chk("rst_valid", fifo_word_t'(m_valid), fifo_word_t'(0));
    chk("rst_data", m_data, fifo_word_t'(0));
    chk("rst_idle", fifo_word_t'(idle), fifo_word_t'(1));
    chk("rst_beat", fifo_word_t'(beat_cnt), fifo_word_t'(0));
    rst = 1'b0;
    step(2);

    // Streaming at full rate.
    preload(8, 1);
    m_ready = 1'b1;
    step(2);
    r0 = rd_count;
    f0 = fire_count;
    first_rd = -1;
    first_fire = -1;
    enable = 1'b1;
    step(20);
    chk("t2_reads", fifo_word_t'(rd_count - r0), fifo_word_t'(8));
    chk("t2_fires", fifo_word_t'(fire_count - f0), fifo_word_t'(8));
    chk("t2_back_to_back", fifo_word_t'(last_fire - first_fire), fifo_word_t'(7));
    chk("t2_latency", fifo_word_t'(first_fire - first_rd), fifo_word_t'(RD_LAT + 1));
    chk("t2_beat_cnt", fifo_word_t'(beat_cnt), fifo_word_t'(8));
    chk("t2_fifo_empty", fifo_word_t'(fifo_q.size()), fifo_word_t'(0));
    enable = 1'b0;
    wait_idle("t2_idle", 30);

    // Single word with almost-empty: one read only.
    preload(1, 'hA5);
    step(2);
    r0 = rd_count;
    v0 = valid_count;
    enable = 1'b1;
    step(10);
    chk("t3_reads", fifo_word_t'(rd_count - r0), fifo_word_t'(1));
    chk("t3_valid_beats", fifo_word_t'(valid_count - v0), fifo_word_t'(1));
    enable = 1'b0;
    wait_idle("t3_idle", 30);

    // Backpressure: reads stop at buffer depth, head holds.
    preload(8, 1);
    m_ready = 1'b0;
    step(2);
    r0 = rd_count;
    f0 = fire_count;
    enable = 1'b1;
    step(10);
    chk("t4_reads_held", fifo_word_t'(rd_count - r0), fifo_word_t'(BUF_D));
    chk("t4_valid", fifo_word_t'(m_valid), fifo_word_t'(1));
    chk("t4_head", m_data, fifo_word_t'(1));
    m_ready = 1'b1;
    step(20);
    chk("t4_fires", fifo_word_t'(fire_count - f0), fifo_word_t'(8));
    chk("t4_fifo_empty", fifo_word_t'(fifo_q.size()), fifo_word_t'(0));
    chk("t6_wrap", fifo_word_t'(beat_cnt), fifo_word_t'(17 % (1 << CNT_W)));
    enable = 1'b0;
    wait_idle("t4_idle", 30);

    // Asynchronous reset with words buffered.
    preload(4, 'h40);
    m_ready = 1'b0;
    step(2);
    enable = 1'b1;
    step(6);
    chk("t1_pre_valid", fifo_word_t'(m_valid), fifo_word_t'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t1_rden", fifo_word_t'(i_rden), fifo_word_t'(0));
    chk("t1_valid", fifo_word_t'(m_valid), fifo_word_t'(0));
    chk("t1_beat", fifo_word_t'(beat_cnt), fifo_word_t'(0));
    chk("t1_idle", fifo_word_t'(idle), fifo_word_t'(1));
    chk("t1_data", m_data, fifo_word_t'(0));
    enable = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    beats_model = 0;
    step(2);
    rst = 1'b0;
    step(2);

    // Disable after three reads.
    preload(8, 'h21);
    m_ready = 1'b1;
    step(2);
    r0 = rd_count;
    f0 = fire_count;
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (i_rden) n++;
    end
    enable = 1'b0;
    step(1);
    wait_idle("t5_idle", 30);
    step(3);
    chk("t5_reads", fifo_word_t'(rd_count - r0), fifo_word_t'(3));
    chk("t5_fires", fifo_word_t'(fire_count - f0), fifo_word_t'(3));
    chk("t5_fifo_left", fifo_word_t'(fifo_q.size()), fifo_word_t'(5));

    // Random traffic, enable toggling and backpressure.
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) enable = !enable;
      if ($urandom_range(0, 9) < 3 && fifo_q.size() < 12)
        fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
      step(1);
    end
    m_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 200 && (fifo_q.size() != 0 || exp_q.size() != 0); i++)
      step(1);
    chk("rnd_fifo_empty", fifo_word_t'(fifo_q.size()), fifo_word_t'(0));
    chk("rnd_all_delivered", fifo_word_t'(exp_q.size()), fifo_word_t'(0));
    enable = 1'b0;
    wait_idle("rnd_idle", 30);
    chk("rnd_no_valid", fifo_word_t'(m_valid), fifo_word_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
